// File: rtl/clk_countdown_timer_pkg.sv
// Shared types, constants and helpers for the MM:SS countdown timer.
package clk_countdown_timer_pkg;

    localparam int unsigned TIME_W           = 8;
    localparam int unsigned SEC_MAX          = 59;
    localparam int unsigned DEF_CLK_HZ       = 1000;
    localparam int unsigned DEF_MAX_MIN      = 99;
    localparam int unsigned DEF_ALARM_CYCLES = 30000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef struct packed {
        logic [TIME_W-1:0] minutes;
        logic [TIME_W-1:0] seconds;
    } mmss_t;

    // Increment with wrap to zero once the top value is reached.
    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max_v);
        return (v >= max_v) ? '0 : v + TIME_W'(1);
    endfunction

endpackage

// File: rtl/clk_countdown_timer_if.sv
// User controls in, display/buzzer outputs out.
interface clk_countdown_timer_if;
    import clk_countdown_timer_pkg::*;

    logic              en;
    logic              clear;
    logic              start_stop;
    logic              enc_sec;
    logic              enc_min;
    logic [TIME_W-1:0] seconds;
    logic [TIME_W-1:0] minutes;
    logic              sec_minus_one;
    logic              timer_done;
    logic              alarm;
    logic              running;

    modport master (
        output en, clear, start_stop, enc_sec, enc_min,
        input  seconds, minutes, sec_minus_one, timer_done, alarm, running
    );

    modport slave (
        input  en, clear, start_stop, enc_sec, enc_min,
        output seconds, minutes, sec_minus_one, timer_done, alarm, running
    );
endinterface

// File: rtl/clk_countdown_timer_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ enabled cycles.
module clk_countdown_timer_prescaler
    import clk_countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] presc_q;

    // Terminal count reached while counting.
    assign tick = en && (presc_q == PRESC_TC);

    // Prescaler counter: cleared by clr, holds while en is low.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (clr) begin
            presc_q <= '0;
        end else if (en) begin
            presc_q <= (presc_q == PRESC_TC) ? '0 : presc_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/clk_countdown_timer.sv
// Kitchen-timer MM:SS down counter with pause, edit and alarm hold.
module clk_countdown_timer
    import clk_countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
    parameter int unsigned MAX_MIN      = DEF_MAX_MIN,
    parameter int unsigned ALARM_CYCLES = DEF_ALARM_CYCLES
) (
    input  logic               CLK,
    input  logic               rst_n,
    clk_countdown_timer_if.slave bus
);

    localparam int unsigned CNT_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ALARM_CYCLES - 1);
    localparam logic [TIME_W-1:0] SEC_TOP  = TIME_W'(SEC_MAX);
    localparam logic [TIME_W-1:0] MIN_TOP  = TIME_W'(MAX_MIN);

    state_e           state_q, state_d;
    mmss_t            time_q, time_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;
    logic             run_q, run_d;

    logic tick;
    logic presc_clr;
    logic presc_en;
    logic time_nz;
    logic time_last;

    // A start from IDLE or a clear restarts the second from zero; a start_stop
    // in RUN freezes the prescaler so a pause keeps the partial second.
    assign presc_clr = ((state_q == ST_IDLE) && bus.start_stop) || bus.clear;
    assign presc_en  = (state_q == ST_RUN) && bus.en && !bus.start_stop;

    clk_countdown_timer_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_presc (
        .CLK   (CLK),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (tick)
    );

    assign time_nz   = (time_q.seconds != '0) || (time_q.minutes != '0);
    assign time_last = (time_q.seconds == TIME_W'(1)) && (time_q.minutes == '0);

    // Next-state, time and alarm counter logic.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        cnt_d   = cnt_q;

        if (bus.clear) begin
            state_d = ST_IDLE;
            time_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_stop) begin
                        if (time_nz) state_d = ST_RUN;
                    end else begin
                        if (bus.enc_sec) time_d.seconds = wrap_inc(time_q.seconds, SEC_TOP);
                        if (bus.enc_min) time_d.minutes = wrap_inc(time_q.minutes, MIN_TOP);
                    end
                end
                ST_RUN: begin
                    if (bus.start_stop) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (time_q.seconds != '0) begin
                            time_d.seconds = time_q.seconds - TIME_W'(1);
                        end else if (time_q.minutes != '0) begin
                            time_d.seconds = SEC_TOP;
                            time_d.minutes = time_q.minutes - TIME_W'(1);
                        end
                        if (time_last) state_d = ST_EXPIRED;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_stop) begin
                        state_d = time_nz ? ST_RUN : ST_IDLE;
                    end else begin
                        if (bus.enc_sec) time_d.seconds = wrap_inc(time_q.seconds, SEC_TOP);
                        if (bus.enc_min) time_d.minutes = wrap_inc(time_q.minutes, MIN_TOP);
                    end
                end
                ST_EXPIRED: begin
                    time_d = '0;
                    if (bus.start_stop || (cnt_q == CNT_LAST)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        done_d  = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
        alarm_d = (state_d == ST_EXPIRED);
        run_d   = (state_d == ST_RUN);
    end

    // State, time and output registers.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            alarm_q <= alarm_d;
            run_q   <= run_d;
        end
    end

    assign bus.seconds       = time_q.seconds;
    assign bus.minutes       = time_q.minutes;
    assign bus.sec_minus_one = tick;
    assign bus.timer_done    = done_q;
    assign bus.alarm         = alarm_q;
    assign bus.running       = run_q;

endmodule
